// File: rtl/iir_wb_sample_master.sv
// Streaming-to-Wishbone initiator for the iir_wishbone filter.
// Each sample goes through X write, settle wait, Y read, then optional STATUS read and output.
module iir_wb_sample_master #(
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned            SETTLE_CYCLES  = 4,
  parameter int unsigned            TIMEOUT_CYCLES = 255,
  parameter bit                     READ_STATUS    = 1'b1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [3:0]            m_ovf,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  input  logic                  clr_err,
  output logic                  timeout_err,
  output logic                  busy,
  output logic [15:0]           sample_count
);

  typedef enum logic [2:0] {
    StIdle, StWrX, StSettle, StRdY, StGap, StRdSt, StOut
  } state_e;

  localparam logic [7:0]            SettleInit  = 8'(SETTLE_CYCLES);
  localparam logic [15:0]           TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] AdrX        = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] AdrY        = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] AdrSt       = BASE_ADDR + ADDR_WIDTH'(8);

  state_e                  state_q, state_d;
  logic [7:0]              settle_q, settle_d;
  logic [15:0]             tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    we_q, we_d;
  logic                    stb_q, stb_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [3:0]              m_ovf_q, m_ovf_d;
  logic                    err_q, err_d;
  logic [15:0]             count_q, count_d;

  logic ack_seen;
  logic timeout;

  // Acks are only meaningful while a strobe is outstanding; ack beats timeout.
  assign ack_seen = wb_ack_i && stb_q;
  assign timeout  = stb_q && !wb_ack_i && (tmo_q == TimeoutLast);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      tmo_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      stb_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ovf_q   <= '0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      stb_q     <= stb_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ovf_q   <= m_ovf_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (s_valid) state_d = StWrX;
      StWrX: begin
        if (ack_seen)     state_d = StSettle;
        else if (timeout) state_d = StIdle;
      end
      StSettle: if (settle_q <= 8'd1) state_d = StRdY;
      StRdY: begin
        if (ack_seen) begin
          if (READ_STATUS) state_d = StGap;
          else             state_d = StOut;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StGap:    state_d = StRdSt;
      StRdSt: begin
        if (ack_seen)     state_d = StOut;
        else if (timeout) state_d = StIdle;
      end
      StOut:    if (m_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    settle_d  = settle_q;
    tmo_d     = stb_q ? tmo_q + 16'd1 : tmo_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    stb_d     = stb_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ovf_d   = m_ovf_q;
    err_d     = timeout | (err_q & ~clr_err);
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          adr_d = AdrX;
          dat_d = s_data;
          we_d  = 1'b1;
          stb_d = 1'b1;
          tmo_d = '0;
        end
      end
      StWrX: begin
        if (ack_seen || timeout) begin
          stb_d = 1'b0;
          we_d  = 1'b0;
          dat_d = '0;
        end
        if (ack_seen) settle_d = SettleInit;
      end
      StSettle: begin
        // Strobe is raised on the edge the counter expires, giving SETTLE_CYCLES idle cycles.
        settle_d = settle_q - 8'd1;
        if (settle_q <= 8'd1) begin
          adr_d = AdrY;
          stb_d = 1'b1;
          tmo_d = '0;
        end
      end
      StRdY: begin
        if (ack_seen) begin
          stb_d    = 1'b0;
          m_data_d = wb_dat_i;
          if (!READ_STATUS) begin
            m_valid_d = 1'b1;
            m_ovf_d   = '0;
          end
        end else if (timeout) begin
          stb_d = 1'b0;
        end
      end
      StGap: begin
        adr_d = AdrSt;
        stb_d = 1'b1;
        tmo_d = '0;
      end
      StRdSt: begin
        if (ack_seen) begin
          stb_d     = 1'b0;
          m_ovf_d   = wb_dat_i[3:0];
          m_valid_d = 1'b1;
        end else if (timeout) begin
          stb_d = 1'b0;
        end
      end
      StOut: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          count_d   = count_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign s_ready      = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_we_o      = we_q;
  assign wb_stb_o     = stb_q;
  assign wb_cyc_o     = stb_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_ovf        = m_ovf_q;
  assign timeout_err  = err_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_iir_wb_sample_master.sv
// Directed bench: instance A uses defaults, instance B uses TIMEOUT_CYCLES=8, READ_STATUS=0.
// Each instance has a behavioural filter responder returning Y = 2*X.
module tb_iir_wb_sample_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] s_data = '0;
  logic m_ready = 1'b1;
  logic clr_err = 1'b0;
  int   wait_n = 0;
  logic no_ack = 1'b0;
  logic [31:0] status_val = '0;

  int checks = 0;
  int errors = 0;

  logic a_s_valid = 1'b0, a_s_ready, a_m_valid, a_we, a_stb, a_cyc, a_err, a_busy;
  logic [31:0] a_m_data, a_dat_o;
  logic [31:0] a_dat_i = '0;
  logic [3:0]  a_m_ovf;
  logic [7:0]  a_adr;
  logic        a_ack = 1'b0;
  logic [15:0] a_cnt;

  logic b_s_valid = 1'b0, b_s_ready, b_m_valid, b_we, b_stb, b_cyc, b_err, b_busy;
  logic [31:0] b_m_data, b_dat_o;
  logic [31:0] b_dat_i = '0;
  logic [3:0]  b_m_ovf;
  logic [7:0]  b_adr;
  logic        b_ack = 1'b0;
  logic [15:0] b_cnt;

  always #5 clk = ~clk;

  iir_wb_sample_master u_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_ovf(a_m_ovf),
    .wb_adr_o(a_adr), .wb_dat_o(a_dat_o), .wb_dat_i(a_dat_i),
    .wb_we_o(a_we), .wb_stb_o(a_stb), .wb_cyc_o(a_cyc), .wb_ack_i(a_ack),
    .clr_err(clr_err), .timeout_err(a_err), .busy(a_busy), .sample_count(a_cnt)
  );

  iir_wb_sample_master #(
    .TIMEOUT_CYCLES(8),
    .READ_STATUS(1'b0)
  ) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_ovf(b_m_ovf),
    .wb_adr_o(b_adr), .wb_dat_o(b_dat_o), .wb_dat_i(b_dat_i),
    .wb_we_o(b_we), .wb_stb_o(b_stb), .wb_cyc_o(b_cyc), .wb_ack_i(b_ack),
    .clr_err(clr_err), .timeout_err(b_err), .busy(b_busy), .sample_count(b_cnt)
  );

  // Responder A: registered ack after wait_n wait states, logs each transaction.
  int          a_wcnt = 0;
  int          a_txn = 0;
  logic [31:0] a_x = '0;
  logic [7:0]  a_log_adr [16];
  logic [31:0] a_log_dat [16];
  logic        a_log_we  [16];
  logic        a_stb_p = 1'b0, a_we_p = 1'b0, a_unstable = 1'b0;
  logic [7:0]  a_adr_p = '0;
  logic [31:0] a_dat_p = '0;

  always @(posedge clk) begin
    a_stb_p <= a_stb;
    a_adr_p <= a_adr;
    a_dat_p <= a_dat_o;
    a_we_p  <= a_we;
    if (a_stb && a_stb_p && (a_adr != a_adr_p || a_dat_o != a_dat_p || a_we != a_we_p))
      a_unstable <= 1'b1;
    if (a_stb && !a_ack && !no_ack && a_wcnt >= wait_n) begin
      a_ack <= 1'b1;
      a_wcnt <= 0;
      a_log_adr[a_txn[3:0]] <= a_adr;
      a_log_dat[a_txn[3:0]] <= a_dat_o;
      a_log_we[a_txn[3:0]]  <= a_we;
      a_txn <= a_txn + 1;
      if (a_we) a_x <= a_dat_o;
      a_dat_i <= (a_adr == 8'h04) ? (a_x << 1) : ((a_adr == 8'h08) ? status_val : 32'hDEAD_BEEF);
    end else begin
      a_ack <= 1'b0;
      if (a_stb && !a_ack) a_wcnt <= a_wcnt + 1;
      else a_wcnt <= 0;
    end
  end

  // Responder B: same behaviour, transaction count only.
  int          b_wcnt = 0;
  int          b_txn = 0;
  logic [31:0] b_x = '0;

  always @(posedge clk) begin
    if (b_stb && !b_ack && !no_ack && b_wcnt >= wait_n) begin
      b_ack <= 1'b1;
      b_wcnt <= 0;
      b_txn <= b_txn + 1;
      if (b_we) b_x <= b_dat_o;
      b_dat_i <= (b_adr == 8'h04) ? (b_x << 1) : ((b_adr == 8'h08) ? status_val : 32'hDEAD_BEEF);
    end else begin
      b_ack <= 1'b0;
      if (b_stb && !b_ack) b_wcnt <= b_wcnt + 1;
      else b_wcnt <= 0;
    end
  end

  // Offer one sample, then count edges until m_valid is seen (bounded).
  task automatic send_a(input logic [31:0] d, output int lat);
    @(negedge clk); s_data = d; a_s_valid = 1'b1;
    @(posedge clk); #1; a_s_valid = 1'b0; s_data = '0;
    lat = 0;
    while (!a_m_valid && lat < 400) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic send_b(input logic [31:0] d, output int lat);
    @(negedge clk); s_data = d; b_s_valid = 1'b1;
    @(posedge clk); #1; b_s_valid = 1'b0; s_data = '0;
    lat = 0;
    while (!b_m_valid && lat < 400) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_cyc, a_stb, a_we} !== 3'b000 || a_adr !== 8'h00 || a_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_bus: cyc/stb/we=%b adr=%h dat=%h, want 000/00/0",
                         {a_cyc, a_stb, a_we}, a_adr, a_dat_o);
    end
    checks++;
    if (a_m_valid !== 1'b0 || a_m_data !== 32'h0 || a_m_ovf !== 4'h0) begin
      errors++; $display("FAIL reset_out: valid=%b data=%h ovf=%h, want 0/0/0",
                         a_m_valid, a_m_data, a_m_ovf);
    end
    checks++;
    if (a_err !== 1'b0 || a_cnt !== 16'h0 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL reset_status: err=%b cnt=%0d busy=%b/%b, want 0/0/0/0",
                         a_err, a_cnt, a_busy, b_busy);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: got %b/%b want 1/1", a_s_ready, b_s_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    int x0;
    x0 = a_txn;
    send_a(32'd100, lat);
    checks++;
    if (lat != 11) begin errors++; $display("FAIL basic_latency: got %0d want 11", lat); end
    checks++;
    if (a_m_data !== 32'd200 || a_m_ovf !== 4'h0) begin
      errors++; $display("FAIL basic_data: data=%0d ovf=%h want 200/0", a_m_data, a_m_ovf);
    end
    checks++;
    if (a_txn - x0 != 3) begin
      errors++; $display("FAIL basic_txn_count: got %0d want 3", a_txn - x0);
    end
    checks++;
    if (a_log_adr[4'(x0)] !== 8'h00 || a_log_dat[4'(x0)] !== 32'd100 || a_log_we[4'(x0)] !== 1'b1)
    begin
      errors++; $display("FAIL basic_write: adr=%h dat=%0d we=%b want 00/100/1",
                         a_log_adr[4'(x0)], a_log_dat[4'(x0)], a_log_we[4'(x0)]);
    end
    checks++;
    if (a_log_adr[4'(x0 + 1)] !== 8'h04 || a_log_we[4'(x0 + 1)] !== 1'b0 ||
        a_log_adr[4'(x0 + 2)] !== 8'h08 || a_log_we[4'(x0 + 2)] !== 1'b0) begin
      errors++; $display("FAIL basic_reads: adr1=%h adr2=%h want 04/08",
                         a_log_adr[4'(x0 + 1)], a_log_adr[4'(x0 + 2)]);
    end
    checks++;
    if (a_dat_o !== 32'h0) begin
      errors++; $display("FAIL basic_dat_idle: wb_dat_o=%h want 0", a_dat_o);
    end
    @(posedge clk); #1;
    checks++;
    if (a_m_valid !== 1'b0 || a_cnt !== 16'd1) begin
      errors++; $display("FAIL basic_handshake: valid=%b cnt=%0d want 0/1", a_m_valid, a_cnt);
    end
  endtask

  task automatic test_wait_states;
    int lat;
    int x0;
    wait_n = 3;
    x0 = a_txn;
    send_a(32'd25, lat);
    checks++;
    if (lat != 20) begin errors++; $display("FAIL wait_latency: got %0d want 20", lat); end
    checks++;
    if (a_m_data !== 32'd50 || a_txn - x0 != 3) begin
      errors++; $display("FAIL wait_data: data=%0d txns=%0d want 50/3", a_m_data, a_txn - x0);
    end
    checks++;
    if (a_unstable !== 1'b0) begin
      errors++; $display("FAIL wait_stable: unstable=%b want 0", a_unstable);
    end
    @(posedge clk); #1;
    wait_n = 0;
    checks++;
    if (a_cnt !== 16'd2) begin errors++; $display("FAIL wait_count: got %0d want 2", a_cnt); end
  endtask

  task automatic test_stall;
    int lat;
    int x0;
    logic bad;
    m_ready = 1'b0;
    send_a(32'd50, lat);
    x0 = a_txn;
    bad = 1'b0;
    checks++;
    if (a_m_data !== 32'd100 || lat != 11) begin
      errors++; $display("FAIL stall_data: data=%0d lat=%0d want 100/11", a_m_data, lat);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (a_m_valid !== 1'b1 || a_m_data !== 32'd100 || a_m_ovf !== 4'h0 ||
          a_s_ready !== 1'b0 || a_cyc !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || a_txn != x0 || a_cnt !== 16'd2) begin
      errors++; $display("FAIL stall_hold: bad=%b txns=%0d cnt=%0d want 0/0/2",
                         bad, a_txn - x0, a_cnt);
    end
    @(negedge clk); m_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_cnt !== 16'd3 || a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: cnt=%0d valid=%b s_ready=%b want 3/0/1",
                         a_cnt, a_m_valid, a_s_ready);
    end
  endtask

  task automatic test_status;
    int lat;
    int x0;
    status_val = 32'h0000_0005;
    send_a(32'd9, lat);
    checks++;
    if (a_m_ovf !== 4'h5 || a_m_data !== 32'd18) begin
      errors++; $display("FAIL status_ovf: ovf=%h data=%0d want 5/18", a_m_ovf, a_m_data);
    end
    @(posedge clk); #1;
    x0 = b_txn;
    send_b(32'd11, lat);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL nostatus_latency: got %0d want 8", lat); end
    checks++;
    if (b_m_ovf !== 4'h0 || b_m_data !== 32'd22 || b_txn - x0 != 2) begin
      errors++; $display("FAIL nostatus_data: ovf=%h data=%0d txns=%0d want 0/22/2",
                         b_m_ovf, b_m_data, b_txn - x0);
    end
    @(posedge clk); #1;
    checks++;
    if (b_cnt !== 16'd1) begin errors++; $display("FAIL nostatus_count: got %0d want 1", b_cnt); end
    status_val = '0;
  endtask

  task automatic test_timeout;
    int   n;
    logic saw;
    no_ack = 1'b1;
    @(negedge clk); s_data = 32'd7; b_s_valid = 1'b1;
    @(posedge clk); #1; b_s_valid = 1'b0; s_data = '0;
    n = 0;
    saw = 1'b0;
    while (b_stb && n < 100) begin
      @(posedge clk); #1; n++;
      if (b_m_valid) saw = 1'b1;
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL timeout_stb_cycles: got %0d want 8", n); end
    checks++;
    if (b_err !== 1'b1 || b_cyc !== 1'b0 || saw !== 1'b0 || b_m_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_flags: err=%b cyc=%b saw_valid=%b want 1/0/0",
                         b_err, b_cyc, saw);
    end
    checks++;
    if (b_s_ready !== 1'b1 || b_busy !== 1'b0 || b_cnt !== 16'd1) begin
      errors++; $display("FAIL timeout_idle: s_ready=%b busy=%b cnt=%0d want 1/0/1",
                         b_s_ready, b_busy, b_cnt);
    end
    no_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", b_err); end
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    checks++;
    if (b_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", b_err); end
  endtask

  task automatic test_reset_mid;
    int n;
    int lat;
    wait_n = 5;
    @(negedge clk); s_data = 32'd3; a_s_valid = 1'b1;
    @(posedge clk); #1; a_s_valid = 1'b0; s_data = '0;
    n = 0;
    while (!(a_stb && a_adr == 8'h04) && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL midreset_reach_rdy: got no Y strobe"); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++;
    if (a_cyc !== 1'b0 || a_stb !== 1'b0 || a_m_valid !== 1'b0 || a_cnt !== 16'd0 ||
        a_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_abort: cyc=%b stb=%b valid=%b cnt=%0d busy=%b want 0s",
                         a_cyc, a_stb, a_m_valid, a_cnt, a_busy);
    end
    wait_n = 0;
    send_a(32'd60, lat);
    checks++;
    if (lat != 11 || a_m_data !== 32'd120) begin
      errors++; $display("FAIL midreset_next: lat=%0d data=%0d want 11/120", lat, a_m_data);
    end
    @(posedge clk); #1;
    checks++;
    if (a_cnt !== 16'd1) begin errors++; $display("FAIL midreset_count: got %0d want 1", a_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_stall();
    test_status();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
